multicycle_controller: RTL and testbench

// - Moore-style main FSM plus ALU/branch decoder sequencing a shared-memory multicycle RV32I datapath.
// - Generates per-cycle mux selects, write enables and ALUControl for the datapath.
// - Replaces single-cycle combinational control; a single memory port is used for both instruction and data.
// - Supported: lw, sw, R-type ALU, I-type ALU, beq/bne/blt/bge/bltu/bgeu, jal; all other opcodes trap.

---
 rtl/mc_pkg.sv | 73 +++++++
 rtl/mc_alu_decoder.sv | 62 ++++++
 rtl/multicycle_controller.sv | 173 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared types and encodings for the multicycle RV32I
//                controller: main FSM state enum, ALUControl codes, opcodes,
//                datapath select encodings and an immediate-format helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by the opcode; anything without an immediate
  // simply gets the I format.
  function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mc_alu_decoder
//  Description : ALUControl selection per FSM state and branch-taken
//                evaluation from funct3 and the ALU comparison flags.
//  Ports       : op, funct3, funct7b5, state  -> alu_control[3:0]
//                Zero, LessThan, LessThanUnsigned, funct3 -> branch_take
//  Revision    : 1.0  initial release
// ============================================================================
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  state_t     state,
  input  logic       Zero,
  input  logic       LessThan,
  input  logic       LessThanUnsigned,
  output logic [3:0] alu_control,
  output logic       branch_take
);

  logic [3:0] arith_op;

  // funct7b5 selects SUB only for register-register ops; addi reuses bit 30
  // as immediate data. For shifts-right it selects SRA in both formats.
  always_comb begin
    case (funct3)
      3'b000:  arith_op = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    case (state)
      S_EXECR, S_EXECI: alu_control = arith_op;
      S_BRANCH:         alu_control = ALU_SUB;
      default:          alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_take = Zero;
      3'b001:  branch_take = !Zero;
      3'b100:  branch_take = LessThan;
      3'b101:  branch_take = !LessThan;
      3'b110:  branch_take = LessThanUnsigned;
      3'b111:  branch_take = !LessThanUnsigned;
      default: branch_take = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Main FSM for a shared-memory multicycle RV32I datapath.
//                Outputs are decoded from the state register (plus funct3 /
//                ALU flags for ALUControl and branch PCWrite).
//  Ports       : clk, reset (sync, active-high); op, funct3, funct7b5 from IR;
//                Zero/LessThan/LessThanUnsigned ALU flags; MemReady (only
//                with MCCTRL_MEM_WAIT_EN); datapath selects, enables,
//                ALUControl, Illegal, InstrRetire.
//  Config      : MCCTRL_MEM_WAIT_EN adds MemReady; FETCH, MEMREAD and
//                MEMWRITE stall until it is high.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LessThan,
  input  logic       LessThanUnsigned,
`ifdef MCCTRL_MEM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] immsrc,
  output logic [3:0] ALUControl,
  output logic       Illegal,
  output logic       InstrRetire
);

  state_t state_q, state_d;
  logic   mem_ready;
  logic   branch_take;

`ifdef MCCTRL_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  mc_alu_decoder u_alu_decoder (
    .op               (op),
    .funct3           (funct3),
    .funct7b5         (funct7b5),
    .state            (state_q),
    .Zero             (Zero),
    .LessThan         (LessThan),
    .LessThanUnsigned (LessThanUnsigned),
    .alu_control      (ALUControl),
    .branch_take      (branch_take)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          // funct3 010/011 are unassigned branch encodings
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:         state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:        if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:          state_d = S_FETCH;
      S_MEMWRITE:       if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB:          state_d = S_FETCH;
      S_BRANCH:         state_d = S_FETCH;
      S_JAL:            state_d = S_ALUWB;
      S_TRAP:           state_d = S_TRAP;
      default:          state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    PCWrite     = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    immsrc      = IMM_I;
    Illegal     = 1'b0;
    InstrRetire = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        // OldPC + imm: branch / jal target parked in ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        immsrc  = imm_sel(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        immsrc  = imm_sel(op);
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = RES_READDATA;
        RegWrite    = 1'b1;
        InstrRetire = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        MemWrite    = mem_ready;
        InstrRetire = mem_ready;
      end
      S_EXECR: ALUSrcA = SRCA_RS1;
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        immsrc  = imm_sel(op);
      end
      S_ALUWB: begin
        RegWrite    = 1'b1;
        InstrRetire = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = SRCA_RS1;
        PCWrite     = branch_take;
        InstrRetire = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_TRAP: Illegal = 1'b1;
      default: ;
    endcase
    // Architectural side effects are suppressed in any cycle reset is high.
    if (reset) begin
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      InstrRetire = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller: directed
//                vector table, instruction-level reference model under random
//                stimulus, and hand sequences for trap / reset / stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0, LessThan = 1'b0, LessThanUnsigned = 1'b0;
`ifdef MCCTRL_MEM_WAIT_EN
  logic MemReady = 1'b1;
`endif
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, InstrRetire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, immsrc;
  logic [3:0] ALUControl;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LessThan(LessThan), .LessThanUnsigned(LessThanUnsigned),
`ifdef MCCTRL_MEM_WAIT_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .immsrc(immsrc), .ALUControl(ALUControl),
    .Illegal(Illegal), .InstrRetire(InstrRetire)
  );

  typedef struct packed {
    logic pcw, adr, memw, irw, regw;
    logic [1:0] res, sa, sb;
    logic [3:0] alu;
    logic ill, ret;
  } out_t;

  logic [16:0] dut_vec;
  assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, Illegal, InstrRetire};
  logic [4:0] enables;
  assign enables = {PCWrite, MemWrite, IRWrite, RegWrite, InstrRetire};

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic f7,
                       input logic z, input logic l, input logic lu);
    op = o; funct3 = f; funct7b5 = f7;
    Zero = z; LessThan = l; LessThanUnsigned = lu;
    reset = 1'b0;
`ifdef MCCTRL_MEM_WAIT_EN
    MemReady = 1'b1;
`endif
  endtask

  // Reset asserted for one cycle; released by the next drive.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_enables", {27'b0, enables}, 32'h0);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_alu(input bit is_r, input logic [2:0] f, input logic f7);
    case (f)
      3'd0: return (is_r && f7) ? 4'b0001 : 4'b0000;
      3'd1: return 4'b0111;
      3'd2: return 4'b0101;
      3'd3: return 4'b0110;
      3'd4: return 4'b0100;
      3'd5: return f7 ? 4'b1001 : 4'b1000;
      3'd6: return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic ref_take(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  // cls: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal
  task automatic run_model(input int cls, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b);
    out_t q[$];
    out_t o;
    logic [6:0] opc;
    logic [1:0] eimm;
    logic z, lt, ltu;
    z = (a == b); lt = ($signed(a) < $signed(b)); ltu = (a < b);
    case (cls)
      0: begin opc = 7'b0000011; eimm = 2'b00; end
      1: begin opc = 7'b0100011; eimm = 2'b01; end
      2: begin opc = 7'b0110011; eimm = 2'b00; end
      3: begin opc = 7'b0010011; eimm = 2'b00; end
      4: begin opc = 7'b1100011; eimm = 2'b10; end
      default: begin opc = 7'b1101111; eimm = 2'b11; end
    endcase
    o = '0; o.pcw = 1; o.irw = 1; o.res = 2'b10; o.sb = 2'b10; q.push_back(o);
    o = '0; o.sa = 2'b01; o.sb = 2'b01; q.push_back(o);
    if (cls <= 1) begin
      o = '0; o.sa = 2'b10; o.sb = 2'b01; q.push_back(o);
    end
    case (cls)
      0: begin
        o = '0; o.adr = 1; q.push_back(o);
        o = '0; o.res = 2'b01; o.regw = 1; o.ret = 1; q.push_back(o);
      end
      1: begin o = '0; o.adr = 1; o.memw = 1; o.ret = 1; q.push_back(o); end
      2, 3: begin
        o = '0; o.sa = 2'b10; o.sb = (cls == 3) ? 2'b01 : 2'b00;
        o.alu = ref_alu(cls == 2, f3, f7); q.push_back(o);
        o = '0; o.regw = 1; o.ret = 1; q.push_back(o);
      end
      4: begin
        o = '0; o.sa = 2'b10; o.alu = 4'b0001; o.ret = 1;
        o.pcw = ref_take(f3, a, b); q.push_back(o);
      end
      default: begin
        o = '0; o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1; q.push_back(o);
        o = '0; o.regw = 1; o.ret = 1; q.push_back(o);
      end
    endcase
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      drive(opc, f3, f7, z, lt, ltu);
      #1;
      check($sformatf("model_cls%0d_f3%0d_cyc%0d", cls, f3, k + 1), {15'b0, dut_vec}, {15'b0, q[k]});
      if (k == 1 && cls != 2)
        check($sformatf("model_imm_cls%0d", cls), {30'b0, immsrc}, {30'b0, eimm});
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, lt, ltu;
    int         len;
    logic [3:0] alu3;
    logic       pcw3;
    logic [7:0] rmask;
  } vec_t;

  vec_t vecs[16];
  int cyc;
  bit done;
  logic [7:0] rmask;
  logic [3:0] alu3;
  logic pcw3;
  int cls;
  logic [2:0] rf3;
  logic rf7;
  logic [31:0] ra, rb;
  logic [2:0] bf3 [6];

  initial begin
    vecs[0]  = '{"lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5, 4'b0000, 1'b0, 8'h10};
    vecs[1]  = '{"sw",       7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 1'b0, 8'h00};
    vecs[2]  = '{"r_sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4, 4'b0001, 1'b0, 8'h08};
    vecs[3]  = '{"r_add",    7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 1'b0, 8'h08};
    vecs[4]  = '{"r_sra",    7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 4, 4'b1001, 1'b0, 8'h08};
    vecs[5]  = '{"r_sltu",   7'b0110011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0110, 1'b0, 8'h08};
    vecs[6]  = '{"r_or",     7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0011, 1'b0, 8'h08};
    vecs[7]  = '{"addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 1'b0, 8'h08};
    vecs[8]  = '{"srli",     7'b0010011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b1000, 1'b0, 8'h08};
    vecs[9]  = '{"andi",     7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0010, 1'b0, 8'h08};
    vecs[10] = '{"bne_z1",   7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3, 4'b0001, 1'b0, 8'h00};
    vecs[11] = '{"bne_z0",   7'b1100011, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 3, 4'b0001, 1'b1, 8'h00};
    vecs[12] = '{"bltu_1",   7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 3, 4'b0001, 1'b1, 8'h00};
    vecs[13] = '{"bge_lt",   7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 3, 4'b0001, 1'b0, 8'h00};
    vecs[14] = '{"beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3, 4'b0001, 1'b1, 8'h00};
    vecs[15] = '{"jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 1'b1, 8'h08};
    bf3[0] = 3'd0; bf3[1] = 3'd1; bf3[2] = 3'd4; bf3[3] = 3'd5; bf3[4] = 3'd6; bf3[5] = 3'd7;

    do_reset();
    // First instruction after reset: full per-cycle comparison from FETCH.
    run_model(0, 3'b010, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      cyc = 0; done = 0; rmask = '0; alu3 = '0; pcw3 = 1'b0;
      while (!done && cyc < 8) begin
        @(negedge clk);
        drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].lt, vecs[i].ltu);
        #1;
        cyc++;
        if (RegWrite) rmask[cyc-1] = 1'b1;
        if (cyc == 3) begin alu3 = ALUControl; pcw3 = PCWrite; end
        if (InstrRetire) done = 1;
      end
      check({vecs[i].name, "_latency"}, cyc, vecs[i].len);
      check({vecs[i].name, "_alu_c3"}, {28'b0, alu3}, {28'b0, vecs[i].alu3});
      check({vecs[i].name, "_pcw_c3"}, {31'b0, pcw3}, {31'b0, vecs[i].pcw3});
      check({vecs[i].name, "_regwrite_cycles"}, {24'b0, rmask}, {24'b0, vecs[i].rmask});
    end

    // Unsupported opcode: trap holds with all enables low.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      if (k >= 2) begin
        check($sformatf("trap_illegal_c%0d", k + 1), {31'b0, Illegal}, 32'h1);
        check($sformatf("trap_enables_c%0d", k + 1), {27'b0, enables}, 32'h0);
      end
    end
    do_reset();
    @(negedge clk);
    drive(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("post_trap_illegal", {31'b0, Illegal}, 32'h0);
    check("post_trap_fetch_irwrite", {31'b0, IRWrite}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Illegal funct3 on a load and on a branch both trap from DECODE.
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (t == 0) drive(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        else        drive(7'b1100011, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
      end
      check($sformatf("bad_f3_trap%0d", t), {31'b0, Illegal}, 32'h1);
      check($sformatf("bad_f3_enables%0d", t), {27'b0, enables}, 32'h0);
      do_reset();
    end

    // Reset landing in MEMWRITE suppresses the store; FETCH follows.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_memwrite_adrsrc", {31'b0, AdrSrc}, 32'h1);
    check("rst_memwrite_memwrite", {31'b0, MemWrite}, 32'h0);
    check("rst_memwrite_enables", {27'b0, enables}, 32'h0);
    run_model(2, 3'b100, 1'b0, 32'h0, 32'h0);

`ifdef MCCTRL_MEM_WAIT_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      MemReady = 1'b0;
      #1;
      check($sformatf("wait_irwrite_c%0d", k), {31'b0, IRWrite}, 32'h0);
      check($sformatf("wait_pcwrite_c%0d", k), {31'b0, PCWrite}, 32'h0);
      check($sformatf("wait_srcb_c%0d", k), {30'b0, ALUSrcB}, 32'h2);
    end
    @(negedge clk);
    drive(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("wait_ready_irwrite", {31'b0, IRWrite}, 32'h1);
    @(negedge clk);
    drive(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("wait_then_decode_srca", {30'b0, ALUSrcA}, 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
`endif

    // Random instruction stream against the instruction-level model.
    for (int n = 0; n < 150; n++) begin
      cls = int'($urandom_range(0, 5));
      rf3 = 3'($urandom_range(0, 7));
      rf7 = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      if (cls <= 1) rf3 = 3'b010;
      if (cls == 4) rf3 = bf3[$urandom_range(0, 5)];
      run_model(cls, rf3, rf7, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
